// File: rtl/ex_disp_sb.sv
// Execute dispatch stage with an in-order OITF scoreboard and a WFI halt handshake.
// Optional stall counter enabled by defining EX_DISP_SB_PERF_CNT_EN.
//
// state | meaning
// RUN   | normal dispatch
// DRAIN | WFI requested, waiting for OITF empty and no AMO in flight
// HALT  | drained, ack asserted until the request drops
module ex_disp_sb #(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int RFIDX_W    = 5,
    parameter int INFO_W     = 32,
    parameter int OITF_DEPTH = 2,
    parameter int ITAG_W     = 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef EX_DISP_SB_PERF_CNT_EN
    output logic [31:0]        disp_stall_cnt,
    input  logic               disp_stall_clr,
`endif
    input  logic               disp_i_valid,
    output logic               disp_i_ready,
    input  logic               disp_i_rs1en,
    input  logic               disp_i_rs2en,
    input  logic [RFIDX_W-1:0] disp_i_rs1idx,
    input  logic [RFIDX_W-1:0] disp_i_rs2idx,
    input  logic [RFIDX_W-1:0] disp_i_rdidx,
    input  logic               disp_i_rdwen,
    input  logic [XLEN-1:0]    disp_i_rs1,
    input  logic [XLEN-1:0]    disp_i_rs2,
    input  logic               disp_i_rs1x0,
    input  logic               disp_i_rs2x0,
    input  logic [XLEN-1:0]    disp_i_imm,
    input  logic [PC_W-1:0]    disp_i_pc,
    input  logic [INFO_W-1:0]  disp_i_info,
    input  logic               disp_i_csr,
    input  logic               disp_i_fence,
    input  logic               disp_i_longp,
    input  logic               disp_i_misalgn,
    input  logic               disp_i_buserr,
    input  logic               disp_i_ilegl,
    output logic               disp_o_alu_valid,
    input  logic               disp_o_alu_ready,
    input  logic               disp_o_alu_longpipe,
    output logic [XLEN-1:0]    disp_o_alu_rs1,
    output logic [XLEN-1:0]    disp_o_alu_rs2,
    output logic [XLEN-1:0]    disp_o_alu_imm,
    output logic [PC_W-1:0]    disp_o_alu_pc,
    output logic [INFO_W-1:0]  disp_o_alu_info,
    output logic               disp_o_alu_rdwen,
    output logic [RFIDX_W-1:0] disp_o_alu_rdidx,
    output logic [ITAG_W-1:0]  disp_o_alu_itag,
    output logic               disp_o_alu_misalgn,
    output logic               disp_o_alu_buserr,
    output logic               disp_o_alu_ilegl,
    input  logic               oitf_ret_ena,
    output logic [ITAG_W-1:0]  oitf_ret_ptr,
    output logic               oitf_ret_rdwen,
    output logic [RFIDX_W-1:0] oitf_ret_rdidx,
    output logic               oitf_empty,
    output logic               oitf_full,
    input  logic               amo_wait,
    input  logic               wfi_halt_exu_req,
    output logic               wfi_halt_exu_ack
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam logic [ITAG_W-1:0] LAST_PTR = ITAG_W'(OITF_DEPTH - 1);

    state_t              state_q, state_d;
    logic [ITAG_W-1:0]   alloc_ptr_q, ret_ptr_q;
    logic                alloc_wrap_q, ret_wrap_q;
    logic [OITF_DEPTH-1:0] ent_vld_q, ent_rdwen_q;
    logic [RFIDX_W-1:0]  ent_rdidx_q [OITF_DEPTH];
    logic                raw, waw, disp_cond, alloc_ena, ret_ena;

    function automatic logic [ITAG_W-1:0] ptr_inc(input logic [ITAG_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign oitf_empty = (alloc_ptr_q == ret_ptr_q) && (alloc_wrap_q == ret_wrap_q);
    assign oitf_full  = (alloc_ptr_q == ret_ptr_q) && (alloc_wrap_q != ret_wrap_q);

    assign alloc_ena = disp_o_alu_valid & disp_o_alu_ready & disp_o_alu_longpipe;
    assign ret_ena   = oitf_ret_ena & ~oitf_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_q  <= '0;
            ret_ptr_q    <= '0;
            alloc_wrap_q <= 1'b0;
            ret_wrap_q   <= 1'b0;
            ent_vld_q    <= '0;
            ent_rdwen_q  <= '0;
        end else begin
            if (ret_ena) begin
                ent_vld_q[ret_ptr_q] <= 1'b0;
                ret_ptr_q            <= ptr_inc(ret_ptr_q);
                if (ret_ptr_q == LAST_PTR) ret_wrap_q <= ~ret_wrap_q;
            end
            if (alloc_ena) begin
                ent_vld_q[alloc_ptr_q]   <= 1'b1;
                ent_rdwen_q[alloc_ptr_q] <= disp_i_rdwen;
                alloc_ptr_q              <= ptr_inc(alloc_ptr_q);
                if (alloc_ptr_q == LAST_PTR) alloc_wrap_q <= ~alloc_wrap_q;
            end
        end
    end

    // Index storage needs no reset: it is only consulted through ent_vld_q.
    always_ff @(posedge clk) begin
        if (alloc_ena) ent_rdidx_q[alloc_ptr_q] <= disp_i_rdidx;
    end

    // A retiring entry still counts as a hazard this cycle.
    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (ent_vld_q[i] && ent_rdwen_q[i]) begin
                if (disp_i_rs1en && (disp_i_rs1idx == ent_rdidx_q[i])) raw = 1'b1;
                if (disp_i_rs2en && (disp_i_rs2idx == ent_rdidx_q[i])) raw = 1'b1;
                if (disp_i_rdwen && (disp_i_rdidx == ent_rdidx_q[i])) waw = 1'b1;
            end
        end
    end

    assign disp_cond = ~raw & ~waw
                     & (~disp_i_longp | ~oitf_full)
                     & (~(disp_i_csr | disp_i_fence) | oitf_empty)
                     & (state_q == RUN)
                     & ~wfi_halt_exu_req;

    assign disp_o_alu_valid = disp_i_valid & disp_cond;
    assign disp_i_ready     = disp_cond & disp_o_alu_ready;

    assign disp_o_alu_rs1     = disp_i_rs1 & {XLEN{~disp_i_rs1x0}};
    assign disp_o_alu_rs2     = disp_i_rs2 & {XLEN{~disp_i_rs2x0}};
    assign disp_o_alu_imm     = disp_i_imm;
    assign disp_o_alu_pc      = disp_i_pc;
    assign disp_o_alu_info    = disp_i_info;
    assign disp_o_alu_rdwen   = disp_i_rdwen;
    assign disp_o_alu_rdidx   = disp_i_rdidx;
    assign disp_o_alu_itag    = alloc_ptr_q;
    assign disp_o_alu_misalgn = disp_i_misalgn;
    assign disp_o_alu_buserr  = disp_i_buserr;
    assign disp_o_alu_ilegl   = disp_i_ilegl;

    assign oitf_ret_ptr   = ret_ptr_q;
    assign oitf_ret_rdwen = ent_rdwen_q[ret_ptr_q];
    assign oitf_ret_rdidx = ent_rdidx_q[ret_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (wfi_halt_exu_req) state_d = DRAIN;
            DRAIN:   if (!wfi_halt_exu_req) state_d = RUN;
                     else if (oitf_empty && !amo_wait) state_d = HALT;
            HALT:    if (!wfi_halt_exu_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign wfi_halt_exu_ack = (state_q == HALT);

`ifdef EX_DISP_SB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || disp_stall_clr)
            disp_stall_cnt <= '0;
        else if (disp_i_valid && !disp_cond && (disp_stall_cnt != 32'hFFFF_FFFF))
            disp_stall_cnt <= disp_stall_cnt + 32'd1;
    end
`endif

endmodule
